decode_operand_stage: RTL and testbench



---
 rtl/decode_operand_stage_pkg.sv | 120 ++++++++++++
 rtl/decode_operand_stage_if.sv | 14 +
 rtl/decode_operand_stage_fwd_select.sv | 39 +++
 rtl/decode_operand_stage.sv | 164 ++++++++++++++++
 tb/tb_decode_operand_stage.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_operand_stage_pkg.sv
// Shared decode constants, branch classes and hold-FSM states for the
// decode/operand stage.
package decode_pkg;

  localparam int unsigned FWD_ADDR_W = 5;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;

  localparam logic [4:0] RI_BLTZ    = 5'h00;
  localparam logic [4:0] RI_BGEZ    = 5'h01;
  localparam logic [4:0] COP0_MTC0  = 5'h04;

  typedef enum logic [3:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BGEZ, BR_BGTZ, BR_BLEZ,
    BR_BLTZ, BR_J, BR_JAL, BR_JR, BR_JALR
  } br_class_e;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } hold_state_e;

  typedef struct packed {
    logic      uses_rs;
    logic      uses_rt;
    br_class_e br_class;
  } dec_info_t;

  function automatic dec_info_t decode_inst(input logic [31:0] inst);
    dec_info_t  d;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    op         = inst[31:26];
    rs         = inst[25:21];
    rt         = inst[20:16];
    fn         = inst[5:0];
    d.uses_rs  = 1'b1;
    d.uses_rt  = 1'b0;
    d.br_class = BR_NONE;
    case (op)
      OP_SPECIAL: begin
        d.uses_rt = 1'b1;
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: d.uses_rs = 1'b0;
          FN_JR: begin
            d.uses_rt  = 1'b0;
            d.br_class = BR_JR;
          end
          FN_JALR: begin
            d.uses_rt  = 1'b0;
            d.br_class = BR_JALR;
          end
          FN_MTHI, FN_MTLO: d.uses_rt = 1'b0;
          FN_SYSCALL, FN_BREAK, FN_MFHI, FN_MFLO: begin
            d.uses_rs = 1'b0;
            d.uses_rt = 1'b0;
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RI_BLTZ)      d.br_class = BR_BLTZ;
        else if (rt == RI_BGEZ) d.br_class = BR_BGEZ;
      end
      OP_J: begin
        d.uses_rs  = 1'b0;
        d.br_class = BR_J;
      end
      OP_JAL: begin
        d.uses_rs  = 1'b0;
        d.br_class = BR_JAL;
      end
      OP_BEQ: begin
        d.uses_rt  = 1'b1;
        d.br_class = BR_BEQ;
      end
      OP_BNE: begin
        d.uses_rt  = 1'b1;
        d.br_class = BR_BNE;
      end
      OP_BLEZ:             d.br_class = BR_BLEZ;
      OP_BGTZ:             d.br_class = BR_BGTZ;
      OP_LUI:              d.uses_rs  = 1'b0;
      OP_COP0: begin
        d.uses_rs = 1'b0;
        d.uses_rt = (rs == COP0_MTC0);
      end
      OP_SB, OP_SH, OP_SW: d.uses_rt  = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_operand_stage_if.sv
// Forwarding bus from the EX/MEM/WB producers into the decode stage;
// entry 0 is the youngest producer.
interface decode_operand_stage_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
);
  logic [NUM_FWD-1:0]                       fwd_we;
  logic [NUM_FWD-1:0]                       fwd_load;
  logic [decode_pkg::FWD_ADDR_W*NUM_FWD-1:0] fwd_waddr;
  logic [XLEN*NUM_FWD-1:0]                  fwd_wdata;

  modport master (output fwd_we, fwd_load, fwd_waddr, fwd_wdata);
  modport slave  (input  fwd_we, fwd_load, fwd_waddr, fwd_wdata);
endinterface

// File: rtl/decode_operand_stage_fwd_select.sv
// Priority forwarding mux for one source operand: r0 reads as zero, else the
// youngest writing producer wins, else regfile data.
module fwd_select
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
) (
  input  logic [FWD_ADDR_W-1:0]         raddr,
  input  logic [XLEN-1:0]               rf_rdata,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD-1:0]            fwd_load,
  input  logic [FWD_ADDR_W*NUM_FWD-1:0] fwd_waddr,
  input  logic [XLEN*NUM_FWD-1:0]       fwd_wdata,
  output logic [XLEN-1:0]               src,
  output logic                          src_load
);

  logic hit;

  always_comb begin
    src      = rf_rdata;
    src_load = 1'b0;
    hit      = 1'b0;
    if (raddr == '0) begin
      src = '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FWD; i++) begin
        if (!hit && fwd_we[i] &&
            (fwd_waddr[i*FWD_ADDR_W +: FWD_ADDR_W] == raddr)) begin
          hit      = 1'b1;
          src      = fwd_wdata[i*XLEN +: XLEN];
          src_load = fwd_load[i];
        end
      end
    end
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode stage: IF->ID pipeline register, stalled-instruction hold register,
// forwarded operand fetch, load-use detection and branch resolution.
module decode_operand_stage
  import decode_pkg::*;
#(
  parameter int unsigned    XLEN    = 32,
  parameter int unsigned    NUM_FWD = 3,
  parameter logic [XLEN-1:0] RST_PC = 32'hBFC0_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_up,
  input  logic                    stall_here,
  input  logic                    flush,
  input  logic                    if_valid,
  input  logic [XLEN-1:0]         if_pc,
  input  logic [31:0]             inst_sram_rdata,
  decode_operand_stage_if.slave   fwd,
  output logic [4:0]              rf_raddr1,
  output logic [4:0]              rf_raddr2,
  input  logic [XLEN-1:0]         rf_rdata1,
  input  logic [XLEN-1:0]         rf_rdata2,
  output logic                    stallreq,
  output logic                    id_valid,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_inst,
  output logic [XLEN-1:0]         id_src1,
  output logic [XLEN-1:0]         id_src2,
  output logic                    br_taken,
  output logic [XLEN-1:0]         br_target,
  output logic                    hold_active
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  hold_state_e     state_q, state_d;
  logic [31:0]     hold_q, hold_d;

  dec_info_t       dec;
  logic            src1_load, src2_load;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] jmp_target;
  logic            br_cond;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall_up && !stall_here) begin
      valid_d = 1'b0;
    end else if (!stall_up) begin
      valid_d = if_valid;
      pc_d    = if_pc;
    end
  end

  // SRAM read data only tracks the PC of the last edge, so the first stalled
  // edge snapshots it and the stage serves from the snapshot until released.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      ST_LIVE: begin
        if (!flush && stall_here && valid_q) begin
          state_d = ST_HELD;
          hold_d  = inst_sram_rdata;
        end
      end
      ST_HELD: begin
        if (!stall_here || flush) state_d = ST_LIVE;
      end
      default: state_d = ST_LIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= RST_PC;
      state_q <= ST_LIVE;
      hold_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    id_inst = '0;
    if (valid_q) id_inst = (state_q == ST_HELD) ? hold_q : inst_sram_rdata;
  end

  assign id_valid    = valid_q;
  assign id_pc       = pc_q;
  assign hold_active = (state_q == ST_HELD);

  assign dec       = decode_inst(id_inst);
  assign rf_raddr1 = id_inst[25:21];
  assign rf_raddr2 = id_inst[20:16];

  fwd_select #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs (
    .raddr     (rf_raddr1),
    .rf_rdata  (rf_rdata1),
    .fwd_we    (fwd.fwd_we),
    .fwd_load  (fwd.fwd_load),
    .fwd_waddr (fwd.fwd_waddr),
    .fwd_wdata (fwd.fwd_wdata),
    .src       (id_src1),
    .src_load  (src1_load)
  );

  fwd_select #(
    .XLEN    (XLEN),
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rt (
    .raddr     (rf_raddr2),
    .rf_rdata  (rf_rdata2),
    .fwd_we    (fwd.fwd_we),
    .fwd_load  (fwd.fwd_load),
    .fwd_waddr (fwd.fwd_waddr),
    .fwd_wdata (fwd.fwd_wdata),
    .src       (id_src2),
    .src_load  (src2_load)
  );

  assign stallreq = valid_q && ((dec.uses_rs && src1_load) ||
                                (dec.uses_rt && src2_load));

  assign pc_plus4   = pc_q + XLEN'(4);
  assign br_off     = {{(XLEN-18){id_inst[15]}}, id_inst[15:0], 2'b00};
  assign jmp_target = {pc_plus4[XLEN-1:28], id_inst[25:0], 2'b00};

  always_comb begin
    br_cond   = 1'b0;
    br_target = pc_plus4 + br_off;
    case (dec.br_class)
      BR_BEQ:  br_cond = (id_src1 == id_src2);
      BR_BNE:  br_cond = (id_src1 != id_src2);
      BR_BGEZ: br_cond = !id_src1[XLEN-1];
      BR_BGTZ: br_cond = !id_src1[XLEN-1] && (id_src1 != '0);
      BR_BLEZ: br_cond = id_src1[XLEN-1] || (id_src1 == '0);
      BR_BLTZ: br_cond = id_src1[XLEN-1];
      BR_J, BR_JAL: begin
        br_cond   = 1'b1;
        br_target = jmp_target;
      end
      BR_JR, BR_JALR: begin
        br_cond   = 1'b1;
        br_target = id_src1;
      end
      default: ;
    endcase
  end

  assign br_taken = br_cond && valid_q && !stallreq && !flush;

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench for decode_operand_stage: vector table for operand fetch and
// branch resolution, plus hand sequences for stall/hold/flush/reset.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_up, stall_here, flush, if_valid;
  logic [31:0] if_pc, sram;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        stallreq, id_valid, br_taken, hold_active;
  logic [31:0] id_pc, id_inst, id_src1, id_src2, br_target;

  int n_vec = 0;
  int n_err = 0;

  decode_operand_stage_if #(.XLEN(32), .NUM_FWD(3)) fwd_bus ();

  decode_operand_stage #(
    .XLEN    (32),
    .NUM_FWD (3),
    .RST_PC  (32'hBFC0_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_up        (stall_up),
    .stall_here      (stall_here),
    .flush           (flush),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .inst_sram_rdata (sram),
    .fwd             (fwd_bus.slave),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .stallreq        (stallreq),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_src1         (id_src1),
    .id_src2         (id_src2),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .hold_active     (hold_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  we;
    logic [2:0]  ld;
    logic [14:0] wa;
    logic [95:0] wd;
    logic [31:0] rf1;
    logic [31:0] rf2;
    logic [31:0] e_src1;
    logic [31:0] e_src2;
    logic        e_stall;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        chk_tgt;
  } vec_t;

  localparam int NV = 24;
  localparam logic [31:0] ADDU  = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] OR00  = 32'h0000_2825; // or $5,$0,$0
  localparam logic [31:0] ADDIU = 32'h2422_0005; // addiu $2,$1,5
  localparam logic [31:0] BNE12 = 32'h1422_FFFF;
  localparam logic [31:0] BEQ12 = 32'h1022_0010;
  localparam logic [31:0] BEQ00 = 32'h1000_0004;
  localparam logic [31:0] BEQ45 = 32'h1085_0002;
  localparam logic [31:0] BGEZ1 = 32'h0421_0003;
  localparam logic [31:0] BLTZ1 = 32'h0420_0003;
  localparam logic [31:0] BGTZ1 = 32'h1C20_0002;
  localparam logic [31:0] BLEZ1 = 32'h1820_0002;
  localparam logic [31:0] JIDX  = 32'h0800_0040;
  localparam logic [31:0] JALX  = 32'h0C00_0010;
  localparam logic [31:0] JR31  = 32'h03E0_0008;

  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic clear_fwd();
    fwd_bus.fwd_we    = '0;
    fwd_bus.fwd_load  = '0;
    fwd_bus.fwd_waddr = '0;
    fwd_bus.fwd_wdata = '0;
  endtask

  task automatic load_slot(input logic [31:0] pc);
    stall_up   = 1'b0;
    stall_here = 1'b0;
    flush      = 1'b0;
    if_valid   = 1'b1;
    if_pc      = pc;
    @(posedge clk);
    #1;
    clear_fwd();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        pc            inst   we     ld     wa                     wd                                  rf1           rf2           src1          src2          st    tk    tgt           ct
    vt[0]  = '{32'h40,       ADDU,  3'b101, 3'b000, {5'd1,5'd0,5'd1},  {32'h99,32'h0,32'h11},             32'hAAAA,     32'hBBBB,     32'h11,       32'hBBBB,     1'b0, 1'b0, 32'h0,        1'b0};
    vt[1]  = '{32'h44,       ADDU,  3'b000, 3'b000, {5'd1,5'd1,5'd2},  {32'h5,32'h6,32'h7},               32'h1111,     32'h2222,     32'h1111,     32'h2222,     1'b0, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{32'h48,       ADDU,  3'b111, 3'b000, {5'd2,5'd2,5'd5},  {32'h33,32'h22,32'hAA},            32'h1,        32'hBBBB,     32'h1,        32'h22,       1'b0, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{32'h4C,       ADDU,  3'b010, 3'b000, {5'd0,5'd1,5'd1},  {32'h0,32'h44,32'h77},             32'hF0,       32'hF1,       32'h44,       32'hF1,       1'b0, 1'b0, 32'h0,        1'b0};
    vt[4]  = '{32'h50,       OR00,  3'b001, 3'b001, {5'd0,5'd0,5'd0},  {32'h0,32'h0,32'h55},              32'hDEAD,     32'hDEAD,     32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{32'h54,       ADDU,  3'b010, 3'b010, {5'd0,5'd2,5'd0},  {32'h0,32'h77,32'h0},              32'h3,        32'h4,        32'h3,        32'h77,       1'b1, 1'b0, 32'h0,        1'b0};
    vt[6]  = '{32'h58,       ADDU,  3'b011, 3'b010, {5'd0,5'd2,5'd2},  {32'h0,32'h77,32'h66},             32'h3,        32'h4,        32'h3,        32'h66,       1'b0, 1'b0, 32'h0,        1'b0};
    vt[7]  = '{32'h5C,       ADDU,  3'b101, 3'b001, {5'd1,5'd0,5'd1},  {32'h99,32'h0,32'h12},             32'h3,        32'h4,        32'h12,       32'h4,        1'b1, 1'b0, 32'h0,        1'b0};
    vt[8]  = '{32'h60,       ADDIU, 3'b001, 3'b001, {5'd0,5'd0,5'd2},  {32'h0,32'h0,32'h88},              32'h3,        32'h4,        32'h3,        32'h88,       1'b0, 1'b0, 32'h0,        1'b0};
    vt[9]  = '{32'h100,      BNE12, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h1,        32'h2,        32'h1,        32'h2,        1'b0, 1'b1, 32'h100,      1'b1};
    vt[10] = '{32'h100,      BNE12, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h9,        32'h9,        32'h9,        32'h9,        1'b0, 1'b0, 32'h100,      1'b1};
    vt[11] = '{32'h200,      BEQ12, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h7,        32'h7,        32'h7,        32'h7,        1'b0, 1'b1, 32'h244,      1'b1};
    vt[12] = '{32'h200,      BEQ12, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h7,        32'h8,        32'h7,        32'h8,        1'b0, 1'b0, 32'h244,      1'b1};
    vt[13] = '{32'h300,      BGEZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b1, 32'h310,      1'b1};
    vt[14] = '{32'h300,      BGEZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h80000000, 32'h0,        32'h80000000, 32'h0,        1'b0, 1'b0, 32'h310,      1'b1};
    vt[15] = '{32'h300,      BLTZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h80000000, 32'h5,        32'h80000000, 32'h0,        1'b0, 1'b1, 32'h310,      1'b1};
    vt[16] = '{32'h300,      BGTZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h0,        32'h5,        32'h0,        32'h0,        1'b0, 1'b0, 32'h30C,      1'b1};
    vt[17] = '{32'h300,      BGTZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h1,        32'h5,        32'h1,        32'h0,        1'b0, 1'b1, 32'h30C,      1'b1};
    vt[18] = '{32'h300,      BLEZ1, 3'b000, 3'b000, 15'h0,             96'h0,                             32'hFFFFFFFF, 32'h5,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h30C,      1'b1};
    vt[19] = '{32'h10000000, JIDX,  3'b000, 3'b000, 15'h0,             96'h0,                             32'h5,        32'h5,        32'h0,        32'h0,        1'b0, 1'b1, 32'h10000100, 1'b1};
    vt[20] = '{32'hBFC00000, JALX,  3'b000, 3'b000, 15'h0,             96'h0,                             32'h5,        32'h5,        32'h0,        32'h0,        1'b0, 1'b1, 32'hB0000040, 1'b1};
    vt[21] = '{32'h40,       JR31,  3'b100, 3'b000, {5'd31,5'd0,5'd0}, {32'h1234,32'h0,32'h0},            32'h5,        32'h5,        32'h1234,     32'h0,        1'b0, 1'b1, 32'h1234,     1'b1};
    vt[22] = '{32'hFFFFFFF0, BEQ00, 3'b000, 3'b000, 15'h0,             96'h0,                             32'h3,        32'h4,        32'h0,        32'h0,        1'b0, 1'b1, 32'h4,        1'b1};
    vt[23] = '{32'h180,      JR31,  3'b001, 3'b001, {5'd0,5'd0,5'd31}, {32'h0,32'h0,32'h0},               32'h5,        32'h5,        32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        1'b0};

    rst        = 1'b0;
    stall_up   = 1'b0;
    stall_here = 1'b0;
    flush      = 1'b0;
    if_valid   = 1'b0;
    if_pc      = '0;
    sram       = 32'h1234_5678;
    rf_rdata1  = '0;
    rf_rdata2  = '0;
    clear_fwd();

    #12;
    chk("rst.id_valid", 32'(id_valid), 32'h0);
    chk("rst.id_inst", id_inst, 32'h0);
    chk("rst.id_pc", id_pc, 32'hBFC0_0000);
    chk("rst.br_taken", 32'(br_taken), 32'h0);
    chk("rst.stallreq", 32'(stallreq), 32'h0);
    chk("rst.hold_active", 32'(hold_active), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < NV; k++) begin
      load_slot(vt[k].pc);
      sram              = vt[k].inst;
      fwd_bus.fwd_we    = vt[k].we;
      fwd_bus.fwd_load  = vt[k].ld;
      fwd_bus.fwd_waddr = vt[k].wa;
      fwd_bus.fwd_wdata = vt[k].wd;
      rf_rdata1         = vt[k].rf1;
      rf_rdata2         = vt[k].rf2;
      #1;
      chk($sformatf("v%0d.id_valid", k), 32'(id_valid), 32'h1);
      chk($sformatf("v%0d.id_pc", k), id_pc, vt[k].pc);
      chk($sformatf("v%0d.id_inst", k), id_inst, vt[k].inst);
      chk($sformatf("v%0d.raddr1", k), 32'(rf_raddr1), 32'(vt[k].inst[25:21]));
      chk($sformatf("v%0d.raddr2", k), 32'(rf_raddr2), 32'(vt[k].inst[20:16]));
      chk($sformatf("v%0d.src1", k), id_src1, vt[k].e_src1);
      chk($sformatf("v%0d.src2", k), id_src2, vt[k].e_src2);
      chk($sformatf("v%0d.stallreq", k), 32'(stallreq), 32'(vt[k].e_stall));
      chk($sformatf("v%0d.br_taken", k), 32'(br_taken), 32'(vt[k].e_taken));
      if (vt[k].chk_tgt) chk($sformatf("v%0d.br_target", k), br_target, vt[k].e_tgt);
    end

    // Three-cycle stall with SRAM data moving on: same inst for four cycles.
    load_slot(32'h400);
    rf_rdata1  = 32'h0;
    rf_rdata2  = 32'h0;
    sram       = ADDU;
    stall_here = 1'b1;
    stall_up   = 1'b1;
    #1;
    chk("hold.c0.id_inst", id_inst, ADDU);
    chk("hold.c0.hold_active", 32'(hold_active), 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      sram = 32'hDEAD_BEEF;
      if (c == 3) begin
        stall_here = 1'b0;
        stall_up   = 1'b0;
        if_pc      = 32'h404;
      end
      #1;
      chk($sformatf("hold.c%0d.id_inst", c), id_inst, ADDU);
      chk($sformatf("hold.c%0d.hold_active", c), 32'(hold_active), 32'h1);
      chk($sformatf("hold.c%0d.id_pc", c), id_pc, 32'h400);
    end
    @(posedge clk);
    #2;
    chk("hold.c4.hold_active", 32'(hold_active), 32'h0);
    chk("hold.c4.id_inst", id_inst, 32'hDEAD_BEEF);
    chk("hold.c4.id_pc", id_pc, 32'h404);

    // Load-use on beq: stall, then resolve once the load data arrives.
    load_slot(32'h500);
    sram              = BEQ45;
    fwd_bus.fwd_we    = 3'b001;
    fwd_bus.fwd_load  = 3'b001;
    fwd_bus.fwd_waddr = {5'd0, 5'd0, 5'd4};
    rf_rdata1         = 32'h0;
    rf_rdata2         = 32'h5;
    stall_here        = 1'b1;
    stall_up          = 1'b1;
    #1;
    chk("lu.stallreq", 32'(stallreq), 32'h1);
    chk("lu.br_taken", 32'(br_taken), 32'h0);
    @(posedge clk);
    #1;
    sram              = 32'hFFFF_FFFF;
    fwd_bus.fwd_load  = 3'b000;
    fwd_bus.fwd_wdata = {32'h0, 32'h0, 32'h5};
    stall_here        = 1'b0;
    stall_up          = 1'b0;
    if_valid          = 1'b0;
    #1;
    chk("lu2.stallreq", 32'(stallreq), 32'h0);
    chk("lu2.hold_active", 32'(hold_active), 32'h1);
    chk("lu2.id_inst", id_inst, BEQ45);
    chk("lu2.src1", id_src1, 32'h5);
    chk("lu2.br_taken", 32'(br_taken), 32'h1);
    chk("lu2.br_target", br_target, 32'h50C);

    // Bubble: upstream stalled while this stage moves on.
    load_slot(32'h600);
    sram       = ADDU;
    stall_up   = 1'b1;
    stall_here = 1'b0;
    #1;
    chk("bub.pre.id_valid", 32'(id_valid), 32'h1);
    @(posedge clk);
    #2;
    chk("bub.id_valid", 32'(id_valid), 32'h0);
    chk("bub.id_inst", id_inst, 32'h0);
    chk("bub.br_taken", 32'(br_taken), 32'h0);

    // Flush gating and flush together with stall while HELD.
    load_slot(32'h700);
    sram       = BEQ00;
    stall_here = 1'b1;
    stall_up   = 1'b1;
    #1;
    chk("fl.br_taken", 32'(br_taken), 32'h1);
    flush = 1'b1;
    #1;
    chk("fl.gated", 32'(br_taken), 32'h0);
    flush = 1'b0;
    @(posedge clk);
    #2;
    chk("fl.held", 32'(hold_active), 32'h1);
    flush = 1'b1;
    @(posedge clk);
    #2;
    chk("fl.hold_active", 32'(hold_active), 32'h0);
    chk("fl.id_valid", 32'(id_valid), 32'h0);
    chk("fl.id_inst", id_inst, 32'h0);
    flush = 1'b0;

    // Asynchronous reset while HELD drops the held instruction.
    load_slot(32'h800);
    sram       = ADDU;
    stall_here = 1'b1;
    stall_up   = 1'b1;
    @(posedge clk);
    #1;
    chk("rh.held", 32'(hold_active), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rh.hold_active", 32'(hold_active), 32'h0);
    chk("rh.id_valid", 32'(id_valid), 32'h0);
    chk("rh.id_pc", id_pc, 32'hBFC0_0000);
    chk("rh.id_inst", id_inst, 32'h0);
    @(posedge clk);
    #1;
    chk("rh.next.id_valid", 32'(id_valid), 32'h0);
    chk("rh.next.hold_active", 32'(hold_active), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rh.rel.hold_active", 32'(hold_active), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
